// File: rtl/fsm_chk_pkg.sv
// Shared types and helpers for the FSM transition checker.
// A rule's delay type is sized per instance from its MAX_DLY (see dly_w).
package fsm_chk_pkg;

  typedef enum logic [1:0] {V_NONE, V_PASS, V_FAIL} verdict_e;

  // Bits needed to count 0..MAX_DLY+1 cycles since arm.
  function automatic int dly_w(input int max_dly);
    return $clog2(max_dly + 2);
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/fsm_chk_rule.sv
// One transition rule: arm compare, delay counter, busy window and verdict.
// o_fail_nxt is the fail about to be registered, so aggregation lines up with o_fail.
module fsm_chk_rule
  import fsm_chk_pkg::*;
#(
  parameter int STATE_W    = 4,
  parameter int MIN_DLY    = 1,
  parameter int MAX_DLY    = 1,
  parameter int EARLY_FAIL = 0,
  parameter int RETRIGGER  = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic [STATE_W-1:0] i_state,
  input  logic [STATE_W-1:0] i_from_state,
  input  logic               i_trigger,
  input  logic               i_expect,
  output logic               o_busy,
  output logic               o_pass,
  output logic               o_fail,
  output logic               o_fail_nxt
);

  localparam int DLY_W = dly_w(MAX_DLY);
  typedef logic [DLY_W-1:0] dly_t;
  localparam dly_t MIN_D = dly_t'(MIN_DLY);
  localparam dly_t MAX_D = dly_t'(MAX_DLY);

  logic     r_busy;
  logic     r_pass;
  logic     r_fail;
  dly_t     r_dly;
  logic     w_arm;
  logic     w_open;
  verdict_e w_verdict;

  always_comb begin
    w_arm     = i_enable && i_trigger && (i_state == i_from_state);
    w_verdict = V_NONE;
    if (r_busy) begin
      if (i_expect && (r_dly >= MIN_D))
        w_verdict = V_PASS;
      else if (i_expect && (EARLY_FAIL != 0))
        w_verdict = V_FAIL;
      else if (!i_expect && (r_dly == MAX_D))
        w_verdict = V_FAIL;
    end
    // A resolving window always frees the slot for a same-cycle arm.
    w_open = w_arm && (!r_busy || (w_verdict != V_NONE) || (RETRIGGER != 0));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_pass <= 1'b0;
      r_fail <= 1'b0;
      r_dly  <= '0;
    end else if (!i_enable) begin
      r_busy <= 1'b0;
      r_pass <= 1'b0;
      r_fail <= 1'b0;
      r_dly  <= '0;
    end else begin
      r_pass <= (w_verdict == V_PASS);
      r_fail <= (w_verdict == V_FAIL);
      if (w_open) begin
        r_busy <= 1'b1;
        r_dly  <= dly_t'(1);
      end else if (w_verdict != V_NONE) begin
        r_busy <= 1'b0;
        r_dly  <= '0;
      end else if (r_busy) begin
        r_dly  <= dly_t'(r_dly + 1'b1);
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_pass     = r_pass;
  assign o_fail     = r_fail;
  assign o_fail_nxt = i_enable && (w_verdict == V_FAIL);

endmodule

// File: rtl/fsm_transition_checker.sv
// Multi-rule FSM transition checker: N_RULES independent windows plus sticky
// error flags, first-fail capture and a saturating failure counter.
module fsm_transition_checker
  import fsm_chk_pkg::*;
#(
  parameter int N_RULES    = 4,
  parameter int STATE_W    = 4,
  parameter int MIN_DLY    = 1,
  parameter int MAX_DLY    = 1,
  parameter int EARLY_FAIL = 0,
  parameter int RETRIGGER  = 0,
  parameter int CNT_W      = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [STATE_W-1:0]           state_value,
  input  logic [N_RULES*STATE_W-1:0]   rule_from_state,
  input  logic [N_RULES-1:0]           trigger,
  input  logic [N_RULES-1:0]           expect_i,
  input  logic                         clear_sticky,
  output logic [N_RULES-1:0]           busy,
  output logic [N_RULES-1:0]           pass_pulse,
  output logic [N_RULES-1:0]           fail_pulse,
  output logic [N_RULES-1:0]           err_sticky,
  output logic                         first_fail_vld,
  output logic [$clog2(N_RULES)-1:0]   first_fail_id,
  output logic [CNT_W-1:0]             fail_count
);

  localparam int ID_W  = $clog2(N_RULES);
  localparam int POP_W = $clog2(N_RULES + 1);

  logic [N_RULES-1:0] w_fail_nxt;
  logic [POP_W-1:0]   w_pop;
  logic [ID_W-1:0]    w_low_id;
  logic [N_RULES-1:0] r_sticky;
  logic               r_ff_vld;
  logic [ID_W-1:0]    r_ff_id;
  logic [CNT_W-1:0]   r_cnt;

  for (genvar gi = 0; gi < N_RULES; gi++) begin : g_rule
    fsm_chk_rule #(
      .STATE_W   (STATE_W),
      .MIN_DLY   (MIN_DLY),
      .MAX_DLY   (MAX_DLY),
      .EARLY_FAIL(EARLY_FAIL),
      .RETRIGGER (RETRIGGER)
    ) u_rule (
      .i_clk       (clock),
      .i_rst       (reset),
      .i_enable    (enable),
      .i_state     (state_value),
      .i_from_state(rule_from_state[gi*STATE_W +: STATE_W]),
      .i_trigger   (trigger[gi]),
      .i_expect    (expect_i[gi]),
      .o_busy      (busy[gi]),
      .o_pass      (pass_pulse[gi]),
      .o_fail      (fail_pulse[gi]),
      .o_fail_nxt  (w_fail_nxt[gi])
    );
  end

  // Descending scan so the lowest failing index is the one left standing.
  always_comb begin
    w_pop    = '0;
    w_low_id = '0;
    for (int i = N_RULES - 1; i >= 0; i--) begin
      w_pop = w_pop + POP_W'(w_fail_nxt[i]);
      if (w_fail_nxt[i])
        w_low_id = ID_W'(i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sticky <= '0;
      r_ff_vld <= 1'b0;
      r_ff_id  <= '0;
      r_cnt    <= '0;
    end else if (clear_sticky) begin
      r_sticky <= w_fail_nxt;
      r_ff_vld <= |w_fail_nxt;
      r_ff_id  <= w_low_id;
      r_cnt    <= CNT_W'(sat_add(32'd0, 32'(w_pop), CNT_W));
    end else begin
      r_sticky <= r_sticky | w_fail_nxt;
      if (!r_ff_vld && (|w_fail_nxt)) begin
        r_ff_vld <= 1'b1;
        r_ff_id  <= w_low_id;
      end
      r_cnt <= CNT_W'(sat_add(32'(r_cnt), 32'(w_pop), CNT_W));
    end
  end

  assign err_sticky     = r_sticky;
  assign first_fail_vld = r_ff_vld;
  assign first_fail_id  = r_ff_id;
  assign fail_count     = r_cnt;

endmodule

// File: tb/tb_fsm_transition_checker.sv
// Bench for fsm_transition_checker: four parameterisations share one stimulus
// stream; each row carries the busy/pass/fail expected after the next edge.
module tb_fsm_transition_checker;

  typedef struct {
    logic       en;
    logic [3:0] st;
    logic [3:0] trig;
    logic [3:0] ex;
    logic       clr;
    logic [11:0] want;
  } row_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  st = '0;
  logic [15:0] from_v = '0;
  logic [3:0]  trig = '0;
  logic [3:0]  expv = '0;
  logic        clr = 1'b0;

  int total = 0;
  int bad   = 0;
  row_t sb[$];

  logic [3:0] busy_a, pass_a, fail_a, sticky_a, busy_b, pass_b, fail_b, sticky_b;
  logic [3:0] busy_c, pass_c, fail_c, sticky_c, busy_d, pass_d, fail_d, sticky_d;
  logic       ffv_a, ffv_b, ffv_c, ffv_d;
  logic [1:0] ffid_a, ffid_b, ffid_c, ffid_d;
  logic [15:0] cnt_a, cnt_b, cnt_c;
  logic [1:0]  cnt_d;
  logic [11:0] obs_a, obs_b, obs_c, obs_d;

  assign obs_a = {busy_a, pass_a, fail_a};
  assign obs_b = {busy_b, pass_b, fail_b};
  assign obs_c = {busy_c, pass_c, fail_c};
  assign obs_d = {busy_d, pass_d, fail_d};

  always #5 clk = ~clk;

  fsm_transition_checker u_a (
    .clock(clk), .reset(rst), .enable(en), .state_value(st), .rule_from_state(from_v),
    .trigger(trig), .expect_i(expv), .clear_sticky(clr), .busy(busy_a),
    .pass_pulse(pass_a), .fail_pulse(fail_a), .err_sticky(sticky_a),
    .first_fail_vld(ffv_a), .first_fail_id(ffid_a), .fail_count(cnt_a));

  fsm_transition_checker #(.MIN_DLY(2), .MAX_DLY(4), .EARLY_FAIL(1)) u_b (
    .clock(clk), .reset(rst), .enable(en), .state_value(st), .rule_from_state(from_v),
    .trigger(trig), .expect_i(expv), .clear_sticky(clr), .busy(busy_b),
    .pass_pulse(pass_b), .fail_pulse(fail_b), .err_sticky(sticky_b),
    .first_fail_vld(ffv_b), .first_fail_id(ffid_b), .fail_count(cnt_b));

  fsm_transition_checker #(.MIN_DLY(2), .MAX_DLY(4), .EARLY_FAIL(0)) u_c (
    .clock(clk), .reset(rst), .enable(en), .state_value(st), .rule_from_state(from_v),
    .trigger(trig), .expect_i(expv), .clear_sticky(clr), .busy(busy_c),
    .pass_pulse(pass_c), .fail_pulse(fail_c), .err_sticky(sticky_c),
    .first_fail_vld(ffv_c), .first_fail_id(ffid_c), .fail_count(cnt_c));

  fsm_transition_checker #(.MAX_DLY(3), .RETRIGGER(1), .CNT_W(2)) u_d (
    .clock(clk), .reset(rst), .enable(en), .state_value(st), .rule_from_state(from_v),
    .trigger(trig), .expect_i(expv), .clear_sticky(clr), .busy(busy_d),
    .pass_pulse(pass_d), .fail_pulse(fail_d), .err_sticky(sticky_d),
    .first_fail_vld(ffv_d), .first_fail_id(ffid_d), .fail_count(cnt_d));

  function automatic row_t mk(input logic e, input logic [3:0] s, input logic [3:0] t,
                              input logic [3:0] x, input logic c, input logic [3:0] b,
                              input logic [3:0] p, input logic [3:0] f);
    row_t r;
    r.en = e; r.st = s; r.trig = t; r.ex = x; r.clr = c; r.want = {b, p, f};
    return r;
  endfunction

  task automatic drive(input row_t r);
    en = r.en; st = r.st; trig = r.trig; expv = r.ex; clr = r.clr;
  endtask

  task automatic apply_reset();
    en = 1'b1; st = '0; trig = '0; expv = '0; clr = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    total++;
    if ({obs_a, sticky_a, ffv_a, ffid_a, cnt_a, obs_d, sticky_d, ffv_d, cnt_d} !== '0) begin
      bad++;
      $display("FAIL reset_state got a=%h/%h/%b/%h d=%h/%h/%b/%h want all zero",
               obs_a, sticky_a, ffv_a, cnt_a, obs_d, sticky_d, ffv_d, cnt_d);
    end
    apply_reset();
  endtask

  task automatic test_pass();
    row_t rows[$];
    row_t e;
    apply_reset();
    rows.push_back(mk(1, 0, 4'b0001, 0, 0, 4'b0001, 0, 0));
    rows.push_back(mk(1, 0, 0, 4'b0001, 0, 0, 4'b0001, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 5, 4'b0001, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 4'b0001, 0, 0, 0, 0, 0));
    foreach (rows[k]) begin
      drive(rows[k]);
      sb.push_back(rows[k]);
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (obs_a !== e.want) begin
        bad++;
        $display("FAIL pass_row%0d busy/pass/fail got=%h want=%h", k, obs_a, e.want);
      end
    end
    total++;
    if ({sticky_a, ffv_a, cnt_a} !== '0) begin
      bad++;
      $display("FAIL pass_no_err got sticky=%h vld=%b cnt=%0d want 0/0/0", sticky_a, ffv_a, cnt_a);
    end
  endtask

  task automatic test_fail();
    row_t rows[$];
    row_t e;
    apply_reset();
    rows.push_back(mk(1, 0, 4'b0001, 0, 0, 4'b0001, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4'b0001));
    foreach (rows[k]) begin
      drive(rows[k]);
      sb.push_back(rows[k]);
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (obs_a !== e.want) begin
        bad++;
        $display("FAIL fail_row%0d busy/pass/fail got=%h want=%h", k, obs_a, e.want);
      end
    end
    total++;
    if ({sticky_a, ffv_a, ffid_a, cnt_a} !== {4'b0001, 1'b1, 2'd0, 16'd1}) begin
      bad++;
      $display("FAIL fail_agg got sticky=%h vld=%b id=%0d cnt=%0d want 1/1/0/1",
               sticky_a, ffv_a, ffid_a, cnt_a);
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    row_t e;
    apply_reset();
    rows.push_back(mk(1, 0, 4'b0001, 0, 0, 4'b0001, 0, 0));
    rows.push_back(mk(1, 0, 4'b0001, 4'b0001, 0, 4'b0001, 4'b0001, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4'b0001));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 0, 4'b1111, 0, 0, 4'b1111, 0, 0));
    rows.push_back(mk(1, 0, 0, 4'b0101, 0, 0, 4'b0101, 4'b1010));
    rows.push_back(mk(1, 0, 4'b0001, 0, 0, 4'b0001, 0, 0));
    rows.push_back(mk(0, 0, 0, 4'b0001, 0, 0, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    foreach (rows[k]) begin
      drive(rows[k]);
      sb.push_back(rows[k]);
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (obs_a !== e.want) begin
        bad++;
        $display("FAIL b2b_row%0d busy/pass/fail got=%h want=%h", k, obs_a, e.want);
      end
    end
    total++;
    if ({ffid_a, cnt_a} !== {2'd0, 16'd3}) begin
      bad++;
      $display("FAIL b2b_count got id=%0d cnt=%0d want 0/3", ffid_a, cnt_a);
    end
  endtask

  task automatic test_early_window();
    row_t rows[$];
    row_t e;
    apply_reset();
    rows.push_back(mk(1, 0, 4'b0001, 0, 0, 4'b0001, 0, 0));
    rows.push_back(mk(1, 0, 0, 4'b0001, 0, 0, 0, 4'b0001));
    rows.push_back(mk(1, 0, 4'b0010, 0, 0, 4'b0010, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 4'b0010, 0, 0));
    rows.push_back(mk(1, 0, 0, 4'b0010, 0, 0, 4'b0010, 0));
    foreach (rows[k]) begin
      drive(rows[k]);
      sb.push_back(rows[k]);
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (obs_b !== e.want) begin
        bad++;
        $display("FAIL early_b_row%0d busy/pass/fail got=%h want=%h", k, obs_b, e.want);
      end
    end
    total++;
    if ({sticky_b, cnt_b} !== {4'b0001, 16'd1}) begin
      bad++;
      $display("FAIL early_b_agg got sticky=%h cnt=%0d want 1/1", sticky_b, cnt_b);
    end
  endtask

  task automatic test_window_ignore();
    row_t rows[$];
    row_t e;
    apply_reset();
    rows.push_back(mk(1, 0, 4'b0001, 0, 0, 4'b0001, 0, 0));
    rows.push_back(mk(1, 0, 0, 4'b0001, 0, 4'b0001, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 4'b0001, 0, 0));
    rows.push_back(mk(1, 0, 0, 4'b0001, 0, 0, 4'b0001, 0));
    rows.push_back(mk(1, 0, 4'b0001, 0, 0, 4'b0001, 0, 0));
    rows.push_back(mk(1, 0, 4'b0001, 0, 0, 4'b0001, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 4'b0001, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 4'b0001, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4'b0001));
    foreach (rows[k]) begin
      drive(rows[k]);
      sb.push_back(rows[k]);
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (obs_c !== e.want) begin
        bad++;
        $display("FAIL window_c_row%0d busy/pass/fail got=%h want=%h", k, obs_c, e.want);
      end
    end
  endtask

  task automatic test_multi_fail_clear();
    row_t rows[$];
    row_t e;
    apply_reset();
    rows.push_back(mk(1, 0, 4'b1010, 0, 0, 4'b1010, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4'b1010));
    foreach (rows[k]) begin
      drive(rows[k]);
      sb.push_back(rows[k]);
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (obs_a !== e.want) begin
        bad++;
        $display("FAIL multi_row%0d busy/pass/fail got=%h want=%h", k, obs_a, e.want);
      end
    end
    total++;
    if ({sticky_a, ffv_a, ffid_a, cnt_a} !== {4'b1010, 1'b1, 2'd1, 16'd2}) begin
      bad++;
      $display("FAIL multi_agg got sticky=%h vld=%b id=%0d cnt=%0d want a/1/1/2",
               sticky_a, ffv_a, ffid_a, cnt_a);
    end
    drive(mk(1, 0, 4'b0100, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    drive(mk(1, 0, 0, 0, 1, 0, 0, 0));
    @(posedge clk); #1;
    total++;
    if ({fail_a, sticky_a, ffv_a, ffid_a, cnt_a} !== {4'b0100, 4'b0100, 1'b1, 2'd2, 16'd1}) begin
      bad++;
      $display("FAIL clear_vs_fail got fail=%h sticky=%h vld=%b id=%0d cnt=%0d want 4/4/1/2/1",
               fail_a, sticky_a, ffv_a, ffid_a, cnt_a);
    end
    drive(mk(1, 0, 0, 0, 1, 0, 0, 0));
    @(posedge clk); #1;
    clr = 1'b0;
    total++;
    if ({sticky_a, ffv_a, cnt_a} !== '0) begin
      bad++;
      $display("FAIL clear_only got sticky=%h vld=%b cnt=%0d want 0/0/0", sticky_a, ffv_a, cnt_a);
    end
  endtask

  task automatic test_retrigger();
    row_t rows[$];
    row_t e;
    apply_reset();
    rows.push_back(mk(1, 0, 4'b0001, 0, 0, 4'b0001, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 4'b0001, 0, 0));
    rows.push_back(mk(1, 0, 4'b0001, 0, 0, 4'b0001, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 4'b0001, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 4'b0001, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4'b0001));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 0, 4'b0001, 0, 0, 4'b0001, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 4'b0001, 0, 0));
    rows.push_back(mk(1, 0, 4'b0001, 0, 0, 4'b0001, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 4'b0001, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    foreach (rows[k]) begin
      drive(rows[k]);
      sb.push_back(rows[k]);
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (obs_d !== e.want) begin
        bad++;
        $display("FAIL retrig_row%0d busy/pass/fail got=%h want=%h", k, obs_d, e.want);
      end
    end
    total++;
    if (cnt_d !== 2'd1) begin
      bad++;
      $display("FAIL retrig_count got=%0d want=1", cnt_d);
    end
  endtask

  task automatic test_saturate_reset();
    row_t rows[$];
    row_t e;
    apply_reset();
    rows.push_back(mk(1, 0, 4'b1111, 0, 0, 4'b1111, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 4'b1111, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 4'b1111, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4'b1111));
    rows.push_back(mk(1, 0, 4'b0001, 0, 0, 4'b0001, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 4'b0001, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 4'b0001, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4'b0001));
    rows.push_back(mk(1, 0, 4'b0010, 0, 0, 4'b0010, 0, 0));
    foreach (rows[k]) begin
      drive(rows[k]);
      sb.push_back(rows[k]);
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (obs_d !== e.want) begin
        bad++;
        $display("FAIL sat_row%0d busy/pass/fail got=%h want=%h", k, obs_d, e.want);
      end
      if (k == 3 || k == 7) begin
        total++;
        if ({cnt_d, sticky_d} !== {2'd3, 4'b1111}) begin
          bad++;
          $display("FAIL sat_count_row%0d got cnt=%0d sticky=%h want 3/f", k, cnt_d, sticky_d);
        end
      end
    end
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0));
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({obs_d, sticky_d, ffv_d, ffid_d, cnt_d} !== '0) begin
      bad++;
      $display("FAIL mid_reset got obs=%h sticky=%h vld=%b cnt=%0d want all zero",
               obs_d, sticky_d, ffv_d, cnt_d);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (obs_d !== '0) begin
      bad++;
      $display("FAIL post_reset_pulse got obs=%h want 0", obs_d);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_back_to_back();
    test_early_window();
    test_window_ignore();
    test_multi_fail_clear();
    test_retrigger();
    test_saturate_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
